count_sequence_monitor: RTL
===========================

// Module: count_sequence_monitor
// PURPOSE
// Watches the count bus of the self-correcting counter, together with the same enable that drives it.
// Checks every cycle-to-cycle step against the legal modulo sequence.
// Flags sequence breaks and out-of-range states, emits a terminal-count wrap pulse, and keeps a saturating error tally.
// Sits directly downstream of the counter. Its status outputs feed the status/interrupt logic.
// PARAMETERS
// WIDTH     4   width of the count bus being monitored
// MODULUS   10  legal states are 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// LOCK_CNT  2   consecutive good steps needed to enter LOCKED; 1..15
// ERR_W     8   width of the saturating error counter
// PORTS
// clk        in   1      single clock; all logic is rising-edge
// rst        in   1      synchronous reset, active-high
// enable     in   1      the enable driven to the counter, sampled alongside count
// count      in   WIDTH  counter output under observation
// err_clr    in   1      synchronous clear of err_count
// locked     out  1      1 while state is LOCKED
// seq_err    out  1      1-cycle pulse: step mismatch or illegal state while LOCKED
// illegal    out  1      1-cycle pulse: sampled count >= MODULUS, in any state
// wrap       out  1      1-cycle pulse: legal step MODULUS-1 -> 0 with enable, in any state
// err_count  out  ERR_W  saturating count of seq_err events
// BEHAVIOUR
// - Each edge registers prev_count <= count, prev_en <= enable and prev_vld <= 1.
//   prev_vld is cleared by rst.
// - expected = prev_en ? (prev_count==MODULUS-1 ? 0 : prev_count+1) : prev_count.
//   expected is computed at WIDTH bits; no carry beyond WIDTH.
// - A step is good when all three hold: prev_vld=1, prev_count<MODULUS, count==expected.
// - All outputs are registered. A flag for sample k is visible in the cycle after edge k (latency 1).
// - FSM, states UNLOCKED and LOCKED, with good_run counter saturating at LOCK_CNT:
//   - UNLOCKED: a good step increments good_run; any other sample clears it.
//     When good_run reaches LOCK_CNT, go to LOCKED. No seq_err is raised in UNLOCKED.
//   - LOCKED: a good step stays in LOCKED.
//     A mismatch or count>=MODULUS pulses seq_err, goes to UNLOCKED and sets good_run=0.
// - illegal pulses whenever count>=MODULUS, regardless of state.
//   The counter's self-correction to a legal value is then re-learned through UNLOCKED.
// - wrap pulses when prev_vld, prev_en, prev_count==MODULUS-1 and count==0.
// - err_count increments by 1 on each seq_err and holds at 2**ERR_W-1.
//   err_clr has priority: err_clr together with a seq_err in the same cycle gives err_count=1, not 0.
// - enable low: a held count is a good step. A held count with enable high is a mismatch.
// - Reset values: locked=0, seq_err=0, illegal=0, wrap=0, err_count=0, state=UNLOCKED, good_run=0, prev_vld=0.
// - rst asserted mid-operation overrides all other inputs in that cycle.
//   The first sample after reset only primes prev_*; it is never judged.
// CONFIGURATION
// - SEQMON_WRAP_CNT_EN defined: adds output wrap_count [15:0].
//   It increments on each wrap pulse, wraps modulo 2**16, resets to 0 and is not cleared by err_clr.
// - SEQMON_WRAP_CNT_EN undefined: no wrap_count port and no related logic; all other behaviour is identical.
// TESTING
// 1. rst for 2 cycles, then enable=1 with count stepping 0,1,2,...
//    -> locked=1 in the cycle after the 2nd good step; seq_err=0 throughout.
// 2. Locked, enable=1, count 9 -> 0 -> wrap=1 for exactly 1 cycle, locked stays 1.
//    With the macro defined, wrap_count=1.
// 3. Locked, force count 4 -> 6 -> seq_err=1 for 1 cycle, locked=0, err_count=1.
//    Relock occurs after 2 good steps.
// 4. Locked, force count=12 -> illegal=1 and seq_err=1 in the same cycle.
//    Counter recovers to 0 -> illegal=0, with no further seq_err until relocked.
// 5. enable=0 with count held at 5 -> no error. enable=1 with count held at 5 -> seq_err=1.
// 6. err_count=255 and another error -> err_count stays 255.
//    err_clr together with an error -> err_count=1. rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
// Watches the count bus of a modulo counter together with the enable that drives it.
// Each cycle-to-cycle step is judged against the legal modulo sequence. The monitor
// locks after LOCK_CNT consecutive good steps and flags breaks while locked. It also
// flags out-of-range samples, pulses on terminal-count wrap and keeps a saturating
// error tally. All status outputs are registered, so a sample taken at edge k is
// reported in the cycle that follows edge k.
//
// Optional feature macro: SEQMON_WRAP_CNT_EN
//   When defined, a free-running 16-bit wrap_count output is added. It counts wrap
//   pulses and is cleared only by rst.

// Invariant checks on the monitor outputs.
module count_sequence_monitor_chk #(
  parameter int unsigned ERR_W = 32'd8
) (
  input logic             clk,
  input logic             rst,
  input logic             locked,
  input logic             seq_err,
  input logic             illegal,
  input logic             wrap,
  input logic [ERR_W-1:0] err_count
);

  // A sequence error always drops lock in the same cycle it is reported.
  a_seq_err_unlocks : assert property (@(posedge clk) disable iff (rst) !(seq_err && locked));

  // A wrap lands on 0, which is always legal, so wrap and illegal never coincide.
  a_wrap_not_illegal : assert property (@(posedge clk) disable iff (rst) !(wrap && illegal));

  // A reported sequence error always leaves a non-zero tally.
  a_err_nonzero : assert property (@(posedge clk) disable iff (rst) !(seq_err && (err_count == {ERR_W{1'b0}})));

endmodule

module count_sequence_monitor #(
  parameter int unsigned WIDTH    = 32'd4,
  parameter int unsigned MODULUS  = 32'd10,
  parameter int unsigned LOCK_CNT = 32'd2,
  parameter int unsigned ERR_W    = 32'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  input  logic             err_clr,
  output logic             locked,
  output logic             seq_err,
  output logic             illegal,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
`ifdef SEQMON_WRAP_CNT_EN
  ,
  output logic [15:0]      wrap_count
`endif
);

  // Range comparisons are done one bit wider so MODULUS == 2**WIDTH is representable.
  localparam int unsigned      CMP_W    = WIDTH + 32'd1;
  localparam logic [CMP_W-1:0] MOD_EXT  = CMP_W'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULUS - 32'd1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Value the counter must show one edge after holding 'cur' with enable 'en'.
  function automatic logic [WIDTH-1:0] seq_next(input logic [WIDTH-1:0] cur, input logic en);
    logic [WIDTH-1:0] res;
    if (!en) begin
      res = cur;
    end else if (cur == TOP_VAL) begin
      res = {WIDTH{1'b0}};
    end else begin
      res = cur + WIDTH'(1'b1);
    end
    return res;
  endfunction

  // True when a sampled value lies inside 0..MODULUS-1.
  function automatic logic in_range(input logic [WIDTH-1:0] val);
    return ({1'b0, val} < MOD_EXT);
  endfunction

  // Previous-sample history
  logic [WIDTH-1:0] prev_count_r;
  logic             prev_en_r;
  logic             prev_vld_r;

  // Step evaluation
  logic [WIDTH-1:0] expected_s;
  logic             count_legal_s;
  logic             prev_legal_s;
  logic             good_step_s;
  logic             wrap_hit_s;

  // Lock tracking
  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       good_run_r;
  logic [3:0]       good_run_nxt_s;
  logic [3:0]       run_inc_s;
  logic             seq_err_nxt_s;

  // Registered outputs
  logic             locked_r;
  logic             seq_err_r;
  logic             illegal_r;
  logic             wrap_r;
  logic [ERR_W-1:0] err_count_r;
  logic [ERR_W-1:0] err_count_nxt_s;

  // Capture the current sample so the next edge can judge the step from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_count_r <= {WIDTH{1'b0}};
      prev_en_r    <= 1'b0;
      prev_vld_r   <= 1'b0;
    end else begin
      prev_count_r <= count;
      prev_en_r    <= enable;
      prev_vld_r   <= 1'b1;
    end
  end

  // Judge the step from the previous sample to the current one.
  always_comb begin
    expected_s    = seq_next(prev_count_r, prev_en_r);
    count_legal_s = in_range(count);
    prev_legal_s  = in_range(prev_count_r);
    good_step_s   = prev_vld_r & prev_legal_s & (count == expected_s);
    wrap_hit_s    = prev_vld_r & prev_en_r & (prev_count_r == TOP_VAL) &
                    (count == {WIDTH{1'b0}});
  end

  // Next lock state, good-step run length and sequence-error decision.
  always_comb begin
    state_nxt_s    = state_r;
    good_run_nxt_s = good_run_r;
    seq_err_nxt_s  = 1'b0;
    if (good_run_r < LOCK_TGT) begin
      run_inc_s = good_run_r + 4'd1;
    end else begin
      run_inc_s = good_run_r;
    end
    case (state_r)
      ST_UNLOCKED: begin
        if (good_step_s) begin
          good_run_nxt_s = run_inc_s;
          if (run_inc_s >= LOCK_TGT) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_UNLOCKED;
          end
        end else begin
          good_run_nxt_s = 4'd0;
          state_nxt_s    = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (good_step_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          seq_err_nxt_s  = 1'b1;
          good_run_nxt_s = 4'd0;
          state_nxt_s    = ST_UNLOCKED;
        end
      end
      default: begin
        good_run_nxt_s = 4'd0;
        state_nxt_s    = ST_UNLOCKED;
      end
    endcase
  end

  // Lock state and run-length registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_UNLOCKED;
      good_run_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      good_run_r <= good_run_nxt_s;
    end
  end

  // Saturating error tally; a clear coinciding with an error leaves a count of one.
  always_comb begin
    err_count_nxt_s = err_count_r;
    if (err_clr) begin
      err_count_nxt_s = ERR_W'(seq_err_nxt_s);
    end else if (seq_err_nxt_s && (err_count_r != ERR_MAX)) begin
      err_count_nxt_s = err_count_r + ERR_W'(1'b1);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // Status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_r    <= 1'b0;
      seq_err_r   <= 1'b0;
      illegal_r   <= 1'b0;
      wrap_r      <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      locked_r    <= (state_nxt_s == ST_LOCKED);
      seq_err_r   <= seq_err_nxt_s;
      illegal_r   <= ~count_legal_s;
      wrap_r      <= wrap_hit_s;
      err_count_r <= err_count_nxt_s;
    end
  end

  assign locked    = locked_r;
  assign seq_err   = seq_err_r;
  assign illegal   = illegal_r;
  assign wrap      = wrap_r;
  assign err_count = err_count_r;

`ifdef SEQMON_WRAP_CNT_EN
  logic [15:0] wrap_count_r;

  // Free-running wrap tally, modulo 2**16, untouched by err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_count_r <= 16'd0;
    end else if (wrap_hit_s) begin
      wrap_count_r <= wrap_count_r + 16'd1;
    end else begin
      wrap_count_r <= wrap_count_r;
    end
  end

  assign wrap_count = wrap_count_r;
`endif

  count_sequence_monitor_chk #(
    .ERR_W(ERR_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked_r),
    .seq_err  (seq_err_r),
    .illegal  (illegal_r),
    .wrap     (wrap_r),
    .err_count(err_count_r)
  );

endmodule
